det_window_counter: RTL and testbench

DET_WINDOW_COUNTER -- requirements
Module: det_window_counter

---
 rtl/det_window_counter.sv | 115 +++++++++++
 tb/tb_det_window_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/det_window_counter.sv
// ============================================================================
// Module   : det_window_counter
// Purpose  : Counts detection pulses over fixed windows and publishes each
//            window's count through a one-entry buffer with overflow pulse.
//            Optional alarm comparator enabled by macro DET_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module det_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             e,
    input  logic             ack,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_vld,
    output logic             ovf,
    output logic             alarm
);

    localparam int               WC_W   = $clog2(WIN_LEN);
    localparam logic [WC_W-1:0]  C_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             close;
    logic             load;
    logic [CNT_W-1:0] snap;

    assign close = (win_cnt_q == C_LAST);
    // Snapshot includes the event arriving on the close cycle itself.
    assign snap  = (e && (acc_q != C_MAX)) ? acc_q + 1'b1 : acc_q;

    always_comb begin
        win_cnt_d = close ? '0 : win_cnt_q + 1'b1;
        acc_d     = close ? '0 : snap;
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (close) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (close) begin
                    if (ack) load  = 1'b1;
                    else     ovf_d = 1'b1;
                end else if (ack) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) cnt_d = snap;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= EMPTY;
            win_cnt_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cnt_out = cnt_q;
    assign cnt_vld = (state_q == FULL);
    assign ovf     = ovf_q;

`ifdef DET_ALARM_EN
    logic alarm_q, alarm_d;

    // Alarm follows only published results; dropped snapshots leave it alone.
    always_comb begin
        alarm_d = alarm_q;
        if (load) alarm_d = (snap >= CNT_W'(THRESH));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) alarm_q <= 1'b0;
        else      alarm_q <= alarm_d;
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_det_window_counter.sv
// ============================================================================
// Module   : tb_det_window_counter
// Purpose  : Directed, table-driven self-checking bench for det_window_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_det_window_counter;

`ifdef DET_ALARM_EN
    localparam bit C_ALARM_EN = 1'b1;
`else
    localparam bit C_ALARM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr, e, ack;
    logic [7:0] cnt_out;
    logic       cnt_vld, ovf, alarm;

    logic       clr_s, e_s, ack_s;
    logic [2:0] cnt_s;
    logic       vld_s, ovf_s, alarm_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    det_window_counter #(.WIN_LEN(16), .CNT_W(8), .THRESH(4)) dut (
        .clk(clk), .clr(clr), .e(e), .ack(ack),
        .cnt_out(cnt_out), .cnt_vld(cnt_vld), .ovf(ovf), .alarm(alarm)
    );

    det_window_counter #(.WIN_LEN(16), .CNT_W(3), .THRESH(4)) dut_s (
        .clk(clk), .clr(clr_s), .e(e_s), .ack(ack_s),
        .cnt_out(cnt_s), .cnt_vld(vld_s), .ovf(ovf_s), .alarm(alarm_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mode: 0 = ack low all window, 1 = ack high all window, 2 = ack only on close cycle
    typedef struct {
        int n_e;
        int mode;
        int exp_cnt;
        bit exp_vld;
        bit exp_ovf;
        bit exp_alarm;
    } vec_t;

    vec_t tbl[10];
    bit   prev_vld;

    // Drives one full window from win_cnt==0; returns at posedge+1 after close.
    task automatic run_window(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("win%0d", idx);
        for (int i = 0; i < 16; i++) begin
            e   = (i < v.n_e);
            ack = (v.mode == 1) || (v.mode == 2 && i == 15);
            @(posedge clk); #1;
            if (i == 0) begin
                chk({tag, "_vld_c0"}, int'(cnt_vld), int'(prev_vld && v.mode != 1));
                chk({tag, "_ovf_c0"}, int'(ovf), 0);
            end
        end
        e = 1'b0; ack = 1'b0;
        chk({tag, "_cnt"},   int'(cnt_out), v.exp_cnt);
        chk({tag, "_vld"},   int'(cnt_vld), int'(v.exp_vld));
        chk({tag, "_ovf"},   int'(ovf),     int'(v.exp_ovf));
        chk({tag, "_alarm"}, int'(alarm),   int'(v.exp_alarm & C_ALARM_EN));
        prev_vld = v.exp_vld;
    endtask

    initial begin
        tbl[0] = '{3,  1, 3,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{2,  1, 2,  1'b1, 1'b0, 1'b0};
        tbl[2] = '{5,  0, 2,  1'b1, 1'b1, 1'b0};
        tbl[3] = '{4,  1, 4,  1'b1, 1'b0, 1'b1};
        tbl[4] = '{3,  1, 3,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{0,  1, 0,  1'b1, 1'b0, 1'b0};
        tbl[6] = '{16, 1, 16, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{15, 0, 16, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1,  0, 16, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{6,  2, 6,  1'b1, 1'b0, 1'b1};

        clr = 1'b1; e = 1'b0; ack = 1'b0;
        clr_s = 1'b1; e_s = 1'b0; ack_s = 1'b0;
        prev_vld = 1'b0;
        #1;
        clr = 1'b0; clr_s = 1'b0;
        #1;
        chk("rst_cnt",   int'(cnt_out), 0);
        chk("rst_vld",   int'(cnt_vld), 0);
        chk("rst_ovf",   int'(ovf),     0);
        chk("rst_alarm", int'(alarm),   0);

        // Saturation on the narrow instance while the main one is held in reset
        @(posedge clk); #1;
        clr_s = 1'b1;
        e = 1'b1; ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e_s = 1'b1;
            @(posedge clk); #1;
        end
        e_s = 1'b0;
        chk("sat_cnt",   int'(cnt_s),   7);
        chk("sat_vld",   int'(vld_s),   1);
        chk("sat_ovf",   int'(ovf_s),   0);
        chk("sat_alarm", int'(alarm_s), int'(C_ALARM_EN));
        chk("inrst_cnt", int'(cnt_out), 0);
        chk("inrst_vld", int'(cnt_vld), 0);
        e = 1'b0; ack = 1'b0;

        clr = 1'b1;
        for (int k = 0; k < 10; k++) run_window(k, tbl[k]);

        // Mid-window reset at win_cnt==9 with acc==4
        for (int i = 0; i < 9; i++) begin
            e = (i < 4);
            @(posedge clk); #1;
        end
        e = 1'b0;
        #2;
        clr = 1'b0;
        #1;
        chk("mid_rst_cnt",   int'(cnt_out), 0);
        chk("mid_rst_vld",   int'(cnt_vld), 0);
        chk("mid_rst_ovf",   int'(ovf),     0);
        chk("mid_rst_alarm", int'(alarm),   0);
        e = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rst_hold_vld", int'(cnt_vld), 0);
        clr = 1'b1;
        ack = 1'b1;
        for (int i = 0; i < 15; i++) begin
            e = (i == 3 || i == 10);
            @(posedge clk); #1;
        end
        e = 1'b0;
        chk("post_rst_no_early", int'(cnt_vld), 0);
        @(posedge clk); #1;
        ack = 1'b0;
        chk("post_rst_cnt", int'(cnt_out), 2);
        chk("post_rst_vld", int'(cnt_vld), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
